// File: rtl/apb_reg_bridge_if.sv
// APB3 bus bundle between the MSS FIC master and the register-block bridge.
interface apb_reg_bridge_if #(
    parameter int APB_AW = 32
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [APB_AW-1:0] PADDR;
    logic [31:0]       PWDATA;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_reg_bridge.sv
// APB3 slave that turns each transfer into a single wr_en/rd_en strobe on the local
// register bus and returns completion, read data and address errors to the master.
module apb_reg_bridge #(
    parameter int APB_AW = 32,
    parameter int REG_AW = 4,
    parameter int DATA_W = 8
) (
    input  logic               clk,
    input  logic               nreset,
    apb_reg_bridge_if.slave    apb,
    output logic               wr_en,
    output logic               rd_en,
    output logic [REG_AW-1:0]  addr,
    output logic [DATA_W-1:0]  data_in,
    input  logic [DATA_W-1:0]  data_out
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD1,
        RD2,
        ACK,
        ERR
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              setup;
    logic              addr_err;
    logic              ready;
    logic              slverr;
    logic [DATA_W-1:0] prdata_q;
    logic              unused_pwdata;

    assign setup    = apb.PSEL && !apb.PENABLE;
    // Only word-aligned addresses inside the register window are legal.
    assign addr_err = (apb.PADDR[1:0] != 2'b00) ||
                      (apb.PADDR[APB_AW-1:REG_AW+2] != '0);

    assign unused_pwdata = ^apb.PWDATA[31:DATA_W];

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        ready     = 1'b0;
        slverr    = 1'b0;
        unique case (state)
            IDLE: begin
                if (setup) begin
                    if (addr_err) begin
                        state_nxt = ERR;
                    end else if (apb.PWRITE) begin
                        state_nxt = WR;
                    end else begin
                        state_nxt = RD1;
                    end
                end
            end
            WR: begin
                wr_en     = 1'b1;
                state_nxt = apb.PSEL ? ACK : IDLE;
            end
            RD1: begin
                rd_en     = 1'b1;
                state_nxt = apb.PSEL ? RD2 : IDLE;
            end
            RD2: begin
                state_nxt = apb.PSEL ? ACK : IDLE;
            end
            ACK: begin
                ready     = 1'b1;
                state_nxt = IDLE;
            end
            ERR: begin
                ready     = 1'b1;
                slverr    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Register-bus address/data are captured at setup and held until the next setup.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            addr     <= '0;
            data_in  <= '0;
            prdata_q <= '0;
        end else begin
            if (state == IDLE && setup) begin
                addr    <= apb.PADDR[REG_AW+1:2];
                data_in <= apb.PWDATA[DATA_W-1:0];
                if (addr_err) begin
                    prdata_q <= '0;
                end
            end
            // data_out is valid the cycle after the rd_en strobe, i.e. during RD2.
            if (state == RD2 && apb.PSEL) begin
                prdata_q <= data_out;
            end
        end
    end

    assign apb.PRDATA  = {{(32-DATA_W){1'b0}}, prdata_q};
    assign apb.PREADY  = ready;
    assign apb.PSLVERR = slverr;

endmodule
